// File: rtl/mult_div_engine.sv
// rtl/mult_div_engine.sv - iterative signed 32x32 multiply / 32/32 divide unit for HI/LO
module mult_div_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] mag_op;
    logic [31:0] p_hi;
    logic [31:0] p_lo;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [63:0] prod_fix;
    logic        accept;

    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;
    assign accept = (ctrl == 2'b01) || (ctrl == 2'b10);

    // Multiply step: p_hi:p_lo is the partial product, low bits of p_lo hold the
    // unconsumed multiplier bits. Divide step: p_hi is the partial remainder,
    // p_lo shifts dividend bits out the top and quotient bits in the bottom.
    assign add_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag_op} : 33'd0);
    assign shifted  = {p_hi, p_lo[31]};
    assign diff     = {1'b0, shifted} - {2'b00, mag_op};
    assign prod_fix = neg_q ? (~{p_hi, p_lo} + 64'd1) : {p_hi, p_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= 5'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mag_op   <= 32'd0;
            p_hi     <= 32'd0;
            p_lo     <= 32'd0;
            hi_out   <= 32'd0;
            lo_out   <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_zero <= 1'b0;
                        if (ctrl[1] && (b == 32'd0)) begin
                            div_zero <= 1'b1;
                        end else begin
                            state  <= S_RUN;
                            count  <= 5'd31;
                            busy   <= 1'b1;
                            is_div <= ctrl[1];
                            neg_q  <= a[31] ^ b[31];
                            neg_r  <= a[31];
                            p_hi   <= 32'd0;
                            if (ctrl[1]) begin
                                mag_op <= abs_b;
                                p_lo   <= abs_a;
                            end else begin
                                mag_op <= abs_a;
                                p_lo   <= abs_b;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        if (!diff[33]) begin
                            p_hi <= diff[31:0];
                            p_lo <= {p_lo[30:0], 1'b1};
                        end else begin
                            p_hi <= shifted[31:0];
                            p_lo <= {p_lo[30:0], 1'b0};
                        end
                    end else begin
                        p_hi <= add_sum[32:1];
                        p_lo <= {add_sum[0], p_lo[31:1]};
                    end
                    count <= count - 5'd1;
                    if (count == 5'd0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        lo_out <= neg_q ? (~p_lo + 32'd1) : p_lo;
                        hi_out <= neg_r ? (~p_hi + 32'd1) : p_hi;
                    end else begin
                        hi_out <= prod_fix[63:32];
                        lo_out <= prod_fix[31:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_engine.md
# mult_div_engine

Iterative signed multiply/divide responder for the multicycle MIPS datapath. It sits between the A/B operand registers and the HI/LO registers. It accepts one command per operation on the 2-bit mult/div control issued by the control unit, then computes over 33 clock edges. It returns a one-cycle completion pulse, or a divide-by-zero flag that the control unit turns into an exception.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- ctrl  in  2  command: 00 none, 01 signed mult, 10 signed div, 11 reserved (treated as none).
- a  in  32  operand A (multiplicand / dividend), sampled only on the accepting edge.
- b  in  32  operand B (multiplier / divisor), sampled only on the accepting edge.
- hi_out  out  32  mult: product[63:32]; div: remainder.
- lo_out  out  32  mult: product[31:0]; div: quotient.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; hi_out/lo_out hold the new result in that cycle.
- div_zero  out  1  divide-by-zero flag.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: ctrl=01 or 10 is accepted on a rising edge; a and b are latched; div_zero is cleared.
  - Divide with b==0: div_zero is set, state stays IDLE, hi/lo are unchanged, no done pulse.
  - Otherwise: state goes to RUN with iteration counter=31.
- RUN: one iteration per edge; counter decrements; on the edge where counter==0, state goes to FIX.
- FIX: one edge. Signs are corrected, hi_out/lo_out are written, done=1, and state returns to IDLE.
- Commands arriving in RUN/FIX are ignored and are not queued. ctrl=11 is always ignored.
- Multiply: sign-magnitude shift-add on |a|, |b|, giving a 64-bit unsigned product. FIX negates it if sign(a) xor sign(b). The result equals the full signed 64-bit product.
- Divide: restoring division on |a|, |b|, giving a 32-bit quotient and remainder.
  - Quotient is negated if sign(a) xor sign(b); truncation is toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. No trap, no overflow flag.
- hi_out/lo_out change only in FIX or on reset. They hold their value indefinitely between operations.
- div_zero stays high until the next accepted command or reset.
- Reset at any point (including mid-RUN) asynchronously forces IDLE. hi_out, lo_out, busy, done, div_zero and all internal registers become 0. A partial result is discarded.

## Timing
- Accepting edge = E0.
- RUN iterations occur on E1..E32; FIX occurs on E33.
- busy=1 in the cycles after E0 through E33 (33 cycles); it is 0 otherwise.
- done=1 only in the cycle after E33; busy=0 in that cycle.
- Earliest next accept is E34, i.e. the done cycle is already IDLE.
- Divide by zero: div_zero=1 in the cycle after E0; busy and done stay 0; a new command is accepted from E1.
- Reset values: hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
- All outputs are registered; there is no combinational path from ctrl/a/b to any output.

## Test plan
- Mult: a=7, b=0xFFFFFFFD (-3), ctrl=01 for one cycle.
  - Expect done exactly 33 edges after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Expect busy high for 33 cycles.
- Mult: a=b=0x80000000.
  - Expect hi=0x40000000, lo=0x00000000.
  - Also: a=0xFFFFFFFF, b=0xFFFFFFFF gives hi=0, lo=1.
- Div: a=0xFFFFFFF9 (-7), b=2, ctrl=10.
  - Expect lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - Then 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- Div by zero: preload hi/lo with a mult, then a=5, b=0, ctrl=10.
  - Expect div_zero=1 next cycle, no done, hi/lo unchanged.
  - A following mult clears div_zero.
- Busy/ignore: while RUN, drive ctrl=10 with other operands and ctrl=11.
  - Expect the result of the original command only, a single done, and no second operation.
- Reset mid-op: assert reset at iteration 10 of a multiply.
  - Expect hi, lo, busy, done and div_zero at 0 immediately, no done pulse.
  - After release, a new div 100/7 gives lo=14, hi=2.
